// File: rtl/kb_event_queue.sv
// Keyboard event queue: detects presses and typematic repeats from the driver's level outputs
// and buffers them in a show-ahead FIFO read by the CPU.
module kb_event_queue #(
  parameter int unsigned DELAY_CYCLES  = 25000000,
  parameter int unsigned REPEAT_CYCLES = 12500000,
  parameter int unsigned DEPTH_LOG2    = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [7:0]            i_ascii,
  input  logic [4:0]            i_mods,
  input  logic                  i_pop,
  input  logic                  i_clr_ovf,
  output logic [31:0]           o_rd_data,
  output logic                  o_empty,
  output logic [DEPTH_LOG2:0]   o_count,
  output logic                  o_overflow,
  output logic                  o_irq
);

  localparam int unsigned Depth = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0] PtrOne = DEPTH_LOG2'(1);
  localparam logic [DEPTH_LOG2:0]   CntOne = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2:0]   CntFull = (DEPTH_LOG2 + 1)'(Depth);
  localparam logic [31:0] DelayLast  = 32'(DELAY_CYCLES - 1);
  localparam logic [31:0] RepeatLast = 32'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StHold, StRepeat} state_e;

  state_e      r_state, w_state_d;
  logic [7:0]  r_key, w_key_d;
  logic [31:0] r_timer, w_timer_d;
  logic        w_push, w_push_rep;
  logic [13:0] w_push_entry;
  logic [31:0] w_limit;

  assign w_limit = (r_state == StHold) ? DelayLast : RepeatLast;

  always_comb begin
    w_state_d  = r_state;
    w_key_d    = r_key;
    w_timer_d  = r_timer;
    w_push     = 1'b0;
    w_push_rep = 1'b0;
    if (r_state == StIdle) begin
      if (i_ascii != 8'd0) begin
        w_push    = 1'b1;
        w_key_d   = i_ascii;
        w_timer_d = 32'd0;
        w_state_d = StHold;
      end
    end else if (i_ascii == 8'd0) begin
      w_timer_d = 32'd0;
      w_state_d = StIdle;
    end else if (i_ascii != r_key) begin
      // A key change is a fresh press and overrides any pending repeat.
      w_push    = 1'b1;
      w_key_d   = i_ascii;
      w_timer_d = 32'd0;
      w_state_d = StHold;
    end else if (r_timer == w_limit) begin
      w_push     = 1'b1;
      w_push_rep = 1'b1;
      w_timer_d  = 32'd0;
      w_state_d  = StRepeat;
    end else begin
      w_timer_d = r_timer + 32'd1;
    end
  end

  assign w_push_entry = {w_push_rep, i_mods, i_ascii};

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= StIdle;
      r_key   <= 8'd0;
      r_timer <= 32'd0;
    end else begin
      r_state <= w_state_d;
      r_key   <= w_key_d;
      r_timer <= w_timer_d;
    end
  end

  logic [13:0]           r_mem [Depth];
  logic [DEPTH_LOG2-1:0] r_wr_ptr, r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_count;
  logic                  r_overflow;
  logic                  w_empty, w_full, w_pop_ok, w_push_ok, w_drop;
  logic [13:0]           w_head;

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == CntFull);
  assign w_pop_ok  = i_pop & ~w_empty;
  // When full, a same-cycle pop frees the slot the push needs.
  assign w_push_ok = w_push & (~w_full | i_pop);
  assign w_drop    = w_push & ~w_push_ok;

  always_ff @(posedge i_clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= w_push_entry;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + PtrOne;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + PtrOne;
      if (w_push_ok && !w_pop_ok)      r_count <= r_count + CntOne;
      else if (!w_push_ok && w_pop_ok) r_count <= r_count - CntOne;
      if (w_drop)         r_overflow <= 1'b1;
      else if (i_clr_ovf) r_overflow <= 1'b0;
    end
  end

  assign w_head     = r_mem[r_rd_ptr];
  assign o_rd_data  = w_empty ? 32'd0 : {16'd0, w_head[13], 2'b00, w_head[12:8], w_head[7:0]};
  assign o_empty    = w_empty;
  assign o_count    = r_count;
  assign o_overflow = r_overflow;
  assign o_irq      = ~w_empty;

endmodule

// File: tb/tb_kb_event_queue.sv
// Directed bench for kb_event_queue with short delays and a 4-entry FIFO.
module tb_kb_event_queue;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  ascii = 8'd0;
  logic [4:0]  mods = 5'd0;
  logic        pop = 1'b0;
  logic        clr_ovf = 1'b0;
  logic [31:0] rd_data;
  logic        empty, overflow, irq;
  logic [2:0]  count;
  int          n_tests = 0;
  int          n_fail = 0;

  kb_event_queue #(.DELAY_CYCLES(8), .REPEAT_CYCLES(4), .DEPTH_LOG2(2)) dut (
    .i_clk(clk), .i_rst(rst), .i_ascii(ascii), .i_mods(mods), .i_pop(pop),
    .i_clr_ovf(clr_ovf), .o_rd_data(rd_data), .o_empty(empty), .o_count(count),
    .o_overflow(overflow), .o_irq(irq)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled at negedges, away from the active edge.
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drain(input string name, input logic [31:0] exp [4], input int n);
    for (int i = 0; i < n; i++) begin
      n_tests++;
      if (rd_data !== exp[i]) begin
        $display("FAIL %s entry %0d: got %h expected %h", name, i, rd_data, exp[i]);
        n_fail++;
      end
      pop = 1'b1;
      tick(1);
      pop = 1'b0;
    end
    n_tests++;
    if (empty !== 1'b1 || count !== 3'd0 || rd_data !== 32'd0) begin
      $display("FAIL %s drained: empty=%b count=%0d rd=%h expected 1/0/0",
               name, empty, count, rd_data);
      n_fail++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(2);
    n_tests++;
    if (empty !== 1'b1 || count !== 3'd0 || rd_data !== 32'd0 || overflow !== 1'b0 ||
        irq !== 1'b0) begin
      $display("FAIL reset: empty=%b count=%0d rd=%h ovf=%b irq=%b expected 1/0/0/0/0",
               empty, count, rd_data, overflow, irq);
      n_fail++;
    end
    rst = 1'b0;
    tick(1);
  endtask

  task automatic test_tap();
    logic [31:0] exp [4];
    ascii = 8'h61;
    tick(3);
    ascii = 8'h00;
    n_tests++;
    if (count !== 3'd1 || rd_data !== 32'h61 || irq !== 1'b1) begin
      $display("FAIL tap: count=%0d rd=%h irq=%b expected 1/00000061/1", count, rd_data, irq);
      n_fail++;
    end
    tick(3);
    n_tests++;
    if (count !== 3'd1) begin
      $display("FAIL tap_single: count=%0d expected 1", count);
      n_fail++;
    end
    exp = '{32'h61, 32'h0, 32'h0, 32'h0};
    drain("tap", exp, 1);
    n_tests++;
    if (irq !== 1'b0) begin
      $display("FAIL tap_irq: irq=%b expected 0", irq);
      n_fail++;
    end
  endtask

  task automatic test_hold();
    logic [31:0] exp [4];
    ascii = 8'h41;
    mods  = 5'b00001;
    tick(17);  // edges N..N+16: press plus repeats at N+8, N+12, N+16
    n_tests++;
    if (count !== 3'd4 || overflow !== 1'b0) begin
      $display("FAIL hold_full: count=%0d ovf=%b expected 4/0", count, overflow);
      n_fail++;
    end
    tick(3);
    n_tests++;
    if (overflow !== 1'b0) begin
      $display("FAIL hold_pre_drop: ovf=%b expected 0", overflow);
      n_fail++;
    end
    tick(1);  // edge N+20: repeat dropped
    n_tests++;
    if (count !== 3'd4 || overflow !== 1'b1) begin
      $display("FAIL hold_drop: count=%0d ovf=%b expected 4/1", count, overflow);
      n_fail++;
    end
    ascii   = 8'h00;
    mods    = 5'd0;
    clr_ovf = 1'b1;
    tick(1);
    clr_ovf = 1'b0;
    n_tests++;
    if (overflow !== 1'b0) begin
      $display("FAIL hold_clr_ovf: ovf=%b expected 0", overflow);
      n_fail++;
    end
    exp = '{32'h141, 32'h8141, 32'h8141, 32'h8141};
    drain("hold", exp, 4);
  endtask

  task automatic test_key_change();
    logic [31:0] exp [4];
    ascii = 8'h61;
    tick(5);
    ascii = 8'h62;
    tick(8);  // change edge plus 7 more: no repeat yet
    n_tests++;
    if (count !== 3'd2) begin
      $display("FAIL key_change_presses: count=%0d expected 2", count);
      n_fail++;
    end
    tick(1);  // 8 edges after the change
    n_tests++;
    if (count !== 3'd3) begin
      $display("FAIL key_change_repeat: count=%0d expected 3", count);
      n_fail++;
    end
    ascii = 8'h00;
    tick(1);
    exp = '{32'h61, 32'h62, 32'h8062, 32'h0};
    drain("key_change", exp, 3);
  endtask

  task automatic test_full_pop();
    logic [31:0] exp [4];
    ascii = 8'h41;
    tick(20);  // full after N+16; next repeat due at N+20
    mods = 5'b00010;
    pop  = 1'b1;
    tick(1);
    pop   = 1'b0;
    ascii = 8'h00;
    mods  = 5'd0;
    n_tests++;
    if (count !== 3'd4 || overflow !== 1'b0) begin
      $display("FAIL full_pop: count=%0d ovf=%b expected 4/0", count, overflow);
      n_fail++;
    end
    tick(1);
    exp = '{32'h8041, 32'h8041, 32'h8041, 32'h8241};
    drain("full_pop", exp, 4);
  endtask

  task automatic test_pop_empty();
    pop = 1'b1;
    tick(3);
    pop = 1'b0;
    n_tests++;
    if (count !== 3'd0 || empty !== 1'b1 || overflow !== 1'b0 || rd_data !== 32'd0) begin
      $display("FAIL pop_empty: count=%0d empty=%b ovf=%b rd=%h expected 0/1/0/0",
               count, empty, overflow, rd_data);
      n_fail++;
    end
  endtask

  task automatic test_reset_mid_repeat();
    ascii = 8'h41;
    tick(21);  // five pushes, one dropped
    pop = 1'b1;
    tick(1);
    pop = 1'b0;
    n_tests++;
    if (count !== 3'd3 || overflow !== 1'b1) begin
      $display("FAIL pre_reset: count=%0d ovf=%b expected 3/1", count, overflow);
      n_fail++;
    end
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if (empty !== 1'b1 || count !== 3'd0 || irq !== 1'b0 || overflow !== 1'b0 ||
        rd_data !== 32'd0) begin
      $display("FAIL async_reset: empty=%b count=%0d irq=%b ovf=%b rd=%h expected 1/0/0/0/0",
               empty, count, irq, overflow, rd_data);
      n_fail++;
    end
    tick(2);
    rst = 1'b0;
    tick(1);
    n_tests++;
    if (count !== 3'd1 || rd_data !== 32'h41) begin
      $display("FAIL post_reset_press: count=%0d rd=%h expected 1/00000041", count, rd_data);
      n_fail++;
    end
    tick(7);
    n_tests++;
    if (count !== 3'd1) begin
      $display("FAIL post_reset_timer: count=%0d expected 1", count);
      n_fail++;
    end
    tick(1);
    n_tests++;
    if (count !== 3'd2) begin
      $display("FAIL post_reset_repeat: count=%0d expected 2", count);
      n_fail++;
    end
    ascii = 8'h00;
    tick(1);
  endtask

  initial begin
    test_reset();
    test_tap();
    test_hold();
    test_key_change();
    test_full_pop();
    test_pop_empty();
    test_reset_mid_repeat();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
